// File: rtl/priority_request_queue_pkg.sv
// Shared types and helpers for the priority request queue: selection ordering,
// output-stage state encoding and the index-width helper.
package prq_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } prio_order_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } out_state_t;

  // Index width that stays at least one bit wide for the smallest legal N.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_request_queue_if.sv
// Request/grant bundle between event sources, the priority queue and its consumer.
interface prq_if #(
  parameter int N     = 8,
  parameter int IDX_W = prq_pkg::idx_width(N)
);
  logic [N-1:0]     req;
  logic [N-1:0]     mask;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     pending;
  logic             any_pending;

  modport master (
    output req,
    output mask,
    output out_ready,
    input  out_idx,
    input  out_valid,
    input  pending,
    input  any_pending
  );

  modport slave (
    input  req,
    input  mask,
    input  out_ready,
    output out_idx,
    output out_valid,
    output pending,
    output any_pending
  );
endinterface

// File: rtl/priority_request_queue_prio_enc.sv
// Combinational vector-to-index priority encoder with hit flag; with N=4 and
// MSB_FIRST=1 it reproduces the legacy 4-to-2 encoder.
module prio_enc_comb #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = prq_pkg::idx_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);
  import prq_pkg::prio_order_t;

  localparam prio_order_t ORDER = (MSB_FIRST != 0) ? prq_pkg::MSB_FIRST : prq_pkg::LSB_FIRST;

  // The last matching bit visited by the scan wins, so scan direction sets priority.
  always_comb begin
    idx = '0;
    hit = |vec;
    if (ORDER == prq_pkg::MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_request_queue.sv
// Sticky request capture with registered highest-priority grant on a
// valid/ready port; the granted channel is retired from pending on load.
//
//   state    | meaning
//   ST_IDLE  | no grant presented, out_valid=0
//   ST_GRANT | out_idx presented, out_valid=1, waiting for out_ready
module priority_request_queue #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = prq_pkg::idx_width(N)
) (
  input logic  clk,
  input logic  rst_n,
  prq_if.slave bus
);
  import prq_pkg::out_state_t;
  import prq_pkg::ST_IDLE;
  import prq_pkg::ST_GRANT;

  out_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_hit;
  logic             load;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     cand;
  logic [N-1:0]     load_onehot;

  assign cand = pend_q & bus.mask;

  prio_enc_comb #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_sel (
    .vec (cand),
    .idx (win_idx),
    .hit (win_hit)
  );

  // No preemption: a presented grant only changes after the consumer takes it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_hit) begin
          state_d = ST_GRANT;
          load    = 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.out_ready) begin
          if (win_hit) load = 1'b1;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) idx_d = win_idx;
  end

  // New requests are ORed in after the clear so a re-request of the loaded bit survives.
  always_comb begin
    load_onehot = '0;
    if (load) load_onehot[win_idx] = 1'b1;
    pend_d = (pend_q & ~load_onehot) | bus.req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.out_idx     = idx_q;
  assign bus.out_valid   = (state_q == ST_GRANT);
  assign bus.pending     = pend_q;
  assign bus.any_pending = |pend_q;

endmodule

// File: doc/priority_request_queue.md
Name: priority_request_queue

Overview:
- Parametrised, registered successor to the team's combinational 4-to-2 priority encoder.
- Captures N sticky request lines into a pending register and selects the highest-priority pending request.
- Presents the selected index on a valid/ready output port and retires it on handshake.
- Sits between interrupt/event sources and a single serialising consumer, e.g. an interrupt controller front end or a DMA channel picker.

Parameters:
- N, 8, number of request channels; legal range 2..64.
- MSB_FIRST, 1, 1 = highest index wins (legacy encoder ordering); 0 = lowest index wins.
- IDX_W, $clog2(N), width of the index output; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request pulses or levels; any high bit sets that channel's pending bit.
- mask  in  N  1 = channel eligible for selection; masked channels stay pending but are never selected.
- out_idx  out  IDX_W  index of the granted channel; meaningful only while out_valid=1.
- out_valid  out  1  grant available.
- out_ready  in  1  consumer accepts; fire = out_valid & out_ready.
- pending  out  N  current pending register, excluding the in-flight grant.
- any_pending  out  1  OR-reduce of pending; this is the legacy "valid" meaning.

Behaviour:
- Reset is asynchronous while rst_n=0:
  - pending, out_idx and out_valid are 0; any_pending is 0.
  - Deassertion is synchronous to clk.
  - A reset mid-transaction discards all pending and in-flight requests.
- Every edge, pending_next = (pending & ~load_onehot) | req:
  - load_onehot is the one-hot of the index loaded this edge, else 0.
  - Set wins over clear: a req on the bit being loaded keeps it pending as a new event.
- Selection is cand = pending & mask.
  - The winner is the highest set bit of cand when MSB_FIRST=1, else the lowest.
  - cand = 0 means no candidate.
- The output register loads when (!out_valid || fire) and cand != 0:
  - out_idx <= winner; out_valid <= 1; the winner's pending bit is cleared (moved into flight).
- When (!out_valid || fire) and cand = 0, out_valid <= 0.
- Stall rule: while out_valid=1 and out_ready=0, out_idx and out_valid hold unchanged, even if a higher-priority request arrives. There is no preemption.
- Latency: a req high at edge k sets pending at edge k. With the output idle, out_valid rises at edge k+1, so grant appears one cycle after pending and two edges after req is first driven.
- Throughput: one grant per cycle with out_ready tied high.
- Repeated req on an already-pending channel is coalesced; there is no count.
- A req on the in-flight channel re-pends it and causes a second grant later.
- mask changes take effect on the next load decision only; an in-flight grant is never revoked.
- All outputs are registered except any_pending, which is combinational from the pending register.

Decomposition:
- Package prq_pkg holds:
  - localparam function clog2-safe IDX_W helper;
  - the enumerated ordering type prio_order_t {LSB_FIRST, MSB_FIRST}.
- Sub-module prio_enc_comb #(N, MSB_FIRST):
  - pure combinational vector-to-index plus hit flag;
  - reused for the selection stage;
  - unit-testable against the legacy 4-to-2 truth table when N=4, MSB_FIRST=1.

Test Plan:
1. Reset with N=8, MSB_FIRST=1, req=8'hA4 held, rst_n=0 -> out_valid=0, pending=0 throughout. After release, pending=A4 one edge later and out_idx=7 one edge after that.
2. Priority ordering: MSB_FIRST=1, mask=FF, single pulse req=8'b0010_0110, out_ready=1 -> grants 5, 2, 1 on consecutive cycles, then out_valid=0 and any_pending=0. With MSB_FIRST=0 the order is 1, 2, 5.
3. Backpressure: grant idx=3 in flight with out_ready=0 for 4 cycles, and req bit 6 pulses meanwhile -> out_idx holds 3 and pending=8'h40. When out_ready=1 the next grant is 6.
4. Masking: pending=8'h81, mask=8'h01 -> grant 0 only, and pending stays 8'h80. Setting mask=FF -> grant 7 on the next load.
5. Simultaneous set/clear: req bit 4 is asserted in the same cycle bit 4 is loaded -> out_idx=4 is granted, and pending[4]=1 afterwards, producing a second grant of 4.
6. Legacy equivalence: N=4, MSB_FIRST=1, sweep single-cycle req=0..15 from empty -> first out_idx matches {0,0,1,1,2,2,2,2,3,...,3}, and any_pending matches {0,1,1,...,1} one edge after req.
